// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer shared definitions
// opcode constants and fetch state type
package fetch_sequencer_pkg;

  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_CALL = 4'b1101;
  localparam logic [3:0] OP_RET  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_ras.sv
// return_addr_stack: circular return-address stack
// with a single sp/count checkpoint for redirect recovery
module return_addr_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               push_data,
  input  logic                       checkpoint,
  input  logic                       restore,
  output logic [W-1:0]               top,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf,
  output logic                       unf
);

  localparam int SP_W  = $clog2(DEPTH);
  localparam int CNT_W = SP_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [SP_W-1:0]  sp;
  logic [SP_W-1:0]  ck_sp;
  logic [CNT_W-1:0] ck_cnt;
  logic             full;
  logic             empty;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign top   = mem[sp - SP_W'(1)];
  assign ovf   = push && full;
  assign unf   = pop && empty;

  // entry storage; a full push lands on the oldest slot
  always_ff @(posedge clk) begin
    if (push && !restore) mem[sp] <= push_data;
  end

  // stack pointer, occupancy and checkpoint
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp     <= '0;
      count  <= '0;
      ck_sp  <= '0;
      ck_cnt <= '0;
    end else begin
      if (restore) begin
        sp    <= ck_sp;
        count <= ck_cnt;
      end else if (push) begin
        sp <= sp + SP_W'(1);
        if (!full) count <= count + CNT_W'(1);
      end else if (pop && !empty) begin
        sp    <= sp - SP_W'(1);
        count <= count - CNT_W'(1);
      end
      if (checkpoint) begin
        ck_sp  <= sp;
        ck_cnt <= count;
      end
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner, fetch register and
// fetch-time resolution of JMP/CALL/RET/HALT
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter int              RAS_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_instr,
  output logic [15:0]     if_instr,
  output logic [PC_W-1:0] if_pc,
  output logic            if_valid,
  input  logic            if_ready,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            resume,
  output logic            halted,
  output logic            ras_ovf,
  output logic            ras_unf
);

  fetch_state_e st;

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] imm;
  logic [PC_W-1:0] ras_top;
  logic [$clog2(RAS_DEPTH):0] ras_count;
  logic [3:0]      op;
  logic            capture;
  logic            push;
  logic            pop;
  logic            restore;
  logic            ovf_p;
  logic            unf_p;

  assign imem_addr = pc;
  assign op        = imem_instr[15:12];
  assign pc_inc    = pc + PC_W'(1);
  assign imm       = PC_W'(imem_instr[11:0]);
  assign capture   = (st == ST_RUN) && !br_taken
                   && (!if_valid || if_ready);
  assign push      = capture && (op == OP_CALL);
  assign pop       = capture && (op == OP_RET);
  assign restore   = br_taken && if_valid;

  // next pc for the word being captured
  always_comb begin
    pc_nxt = pc_inc;
    unique case (op)
      OP_JMP,
      OP_CALL: pc_nxt = imm;
      OP_RET:  pc_nxt = (ras_count == '0)
                      ? RESET_PC : ras_top;
      default: pc_nxt = pc_inc;
    endcase
  end

  return_addr_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .push_data  (pc_inc),
    .checkpoint (capture),
    .restore    (restore),
    .top        (ras_top),
    .count      (ras_count),
    .ovf        (ovf_p),
    .unf        (unf_p)
  );

  // pc, fetch register, run/halt state and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      if_instr <= '0;
      if_pc    <= '0;
      if_valid <= 1'b0;
      st       <= ST_RUN;
      halted   <= 1'b0;
      ras_ovf  <= 1'b0;
      ras_unf  <= 1'b0;
    end else begin
      if (ovf_p) ras_ovf <= 1'b1;
      if (unf_p) ras_unf <= 1'b1;
      if (br_taken) begin
        pc       <= br_target;
        if_valid <= 1'b0;
        st       <= ST_RUN;
        halted   <= 1'b0;
      end else begin
        if (capture) begin
          if_instr <= imem_instr;
          if_pc    <= pc;
          if_valid <= 1'b1;
          pc       <= pc_nxt;
          if (op == OP_HALT) begin
            st     <= ST_HALT;
            halted <= 1'b1;
          end
        end else if (if_ready) begin
          if_valid <= 1'b0;
        end
        if (st == ST_HALT && resume) begin
          st     <= ST_RUN;
          halted <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed program tests with a
// queue-based reference model checked every cycle
module tb_fetch_sequencer;

  localparam int          PC_W  = 16;
  localparam int          DEPTH = 8;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_valid;
  logic        if_ready;
  logic        br_taken;
  logic [15:0] br_target;
  logic        resume;
  logic        halted;
  logic        ras_ovf;
  logic        ras_unf;

  logic [15:0] mem [256];
  assign imem_instr = mem[imem_addr[7:0]];

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .PC_W      (PC_W),
    .RAS_DEPTH (DEPTH),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .resume     (resume),
    .halted     (halted),
    .ras_ovf    (ras_ovf),
    .ras_unf    (ras_unf)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  // reference model: program-level semantics
  logic [15:0] m_pc;
  logic [15:0] m_instr;
  logic [15:0] m_ifpc;
  bit          m_valid;
  bit          m_halt;
  bit          m_ovf;
  bit          m_unf;
  logic [15:0] m_stack [$];
  logic [15:0] m_ck [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = RST_PC; m_instr = '0; m_ifpc = '0;
      m_valid = 0; m_halt = 0;
      m_ovf = 0; m_unf = 0;
      m_stack.delete(); m_ck.delete();
    end else if (br_taken) begin
      if (m_valid) m_stack = m_ck;
      m_pc = br_target;
      m_valid = 0;
      m_halt = 0;
    end else begin
      bit was_halt;
      was_halt = m_halt;
      if (!m_halt && (!m_valid || if_ready)) begin
        logic [15:0] w;
        w = mem[m_pc[7:0]];
        m_ck = m_stack;
        m_instr = w; m_ifpc = m_pc; m_valid = 1;
        case (w[15:12])
          4'hC: m_pc = {4'h0, w[11:0]};
          4'hD: begin
            if (m_stack.size() == DEPTH) begin
              void'(m_stack.pop_front());
              m_ovf = 1;
            end
            m_stack.push_back(m_pc + 16'd1);
            m_pc = {4'h0, w[11:0]};
          end
          4'hE: begin
            if (m_stack.size() == 0) begin
              m_pc = RST_PC;
              m_unf = 1;
            end else m_pc = m_stack.pop_back();
          end
          4'hF: begin m_pc = m_pc + 16'd1; m_halt = 1; end
          default: m_pc = m_pc + 16'd1;
        endcase
      end else if (!(m_valid && !if_ready)) begin
        if (if_ready) m_valid = 0;
      end
      if (was_halt && resume) m_halt = 0;
    end
  end

  // cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_imem_addr", imem_addr, m_pc);
      check("m_if_valid", if_valid, m_valid);
      if (m_valid) begin
        check("m_if_instr", if_instr, m_instr);
        check("m_if_pc", if_pc, m_ifpc);
      end
      check("m_halted", halted, m_halt);
      check("m_ras_ovf", ras_ovf, m_ovf);
      check("m_ras_unf", ras_unf, m_unf);
      check("m_ras_count", 32'(dut.ras_count),
            32'(m_stack.size()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic reset_hold();
    rst_n = 1'b0;
    if_ready = 1'b1; br_taken = 1'b0;
    br_target = '0; resume = 1'b0;
    #1;
  endtask

  task automatic release_rst();
    step(); step();
    rst_n = 1'b1;
  endtask

  initial begin
    reset_hold();
    clear_mem();
    mem[0] = 16'h1001; mem[1] = 16'h1002;
    mem[2] = 16'h1003; mem[3] = 16'h1004;
    step();
    cmp_en = 1'b1;
    check("rst_if_valid", if_valid, 0);
    check("rst_if_instr", if_instr, 0);
    check("rst_if_pc", if_pc, 0);
    check("rst_halted", halted, 0);
    release_rst();
    check("rel_valid0", if_valid, 0);
    check("rel_addr", imem_addr, 16'h0000);
    resume = 1'b1;
    step(); check("t1_pc0", if_pc, 16'd0);
    check("t1_instr0", if_instr, 16'h1001);
    step(); check("t1_pc1", if_pc, 16'd1);
    resume = 1'b0;
    step(); check("t1_pc2", if_pc, 16'd2);
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_stall_pc", if_pc, 16'd2);
      check("t2_stall_instr", if_instr, 16'h1003);
      check("t2_stall_addr", imem_addr, 16'd3);
    end
    if_ready = 1'b1;
    step(); check("t2_resume_pc", if_pc, 16'd3);
    check("t2_resume_instr", if_instr, 16'h1004);

    reset_hold();
    clear_mem();
    mem[0]  = 16'hC006; mem[6]  = 16'hD00A;
    mem[7]  = 16'h2000; mem[10] = 16'h1234;
    mem[11] = 16'hE000;
    release_rst();
    step(); check("t3_pc0", if_pc, 16'd0);
    step(); check("t3_pc6", if_pc, 16'd6);
    check("t3_cnt1", 32'(dut.ras_count), 1);
    step(); check("t3_pc10", if_pc, 16'd10);
    step(); check("t3_pc11", if_pc, 16'd11);
    step(); check("t3_pc7", if_pc, 16'd7);
    check("t3_instr7", if_instr, 16'h2000);
    check("t3_cnt0", 32'(dut.ras_count), 0);
    check("t3_flags", {ras_ovf, ras_unf}, 0);

    reset_hold();
    release_rst();
    step(); step();
    check("t4_call", if_pc, 16'd6);
    br_taken = 1'b1; br_target = 16'd4;
    step();
    br_taken = 1'b0;
    check("t4_valid0", if_valid, 0);
    check("t4_addr4", imem_addr, 16'd4);
    check("t4_cnt0", 32'(dut.ras_count), 0);
    step(); check("t4_pc4", if_pc, 16'd4);

    reset_hold();
    clear_mem();
    mem[0]  = 16'hC00C; mem[12] = 16'hF000;
    mem[13] = 16'h4000; mem[14] = 16'hC00C;
    mem[4]  = 16'h5000;
    release_rst();
    step(); check("t5_pc0", if_pc, 16'd0);
    step(); check("t5_halt_pc", if_pc, 16'd12);
    check("t5_halt_instr", if_instr, 16'hF000);
    check("t5_halted", halted, 1);
    check("t5_addr13", imem_addr, 16'd13);
    step(); check("t5_drain", if_valid, 0);
    step(); check("t5_still", if_valid, 0);
    resume = 1'b1;
    step(); resume = 1'b0;
    check("t5_run", halted, 0);
    step(); check("t5_pc13", if_pc, 16'd13);
    step(); check("t5_pc14", if_pc, 16'd14);
    step(); check("t5_halt2", halted, 1);
    step();
    br_taken = 1'b1; br_target = 16'd4;
    step(); br_taken = 1'b0;
    check("t5_br_run", halted, 0);
    check("t5_br_addr", imem_addr, 16'd4);
    step(); check("t5_br_pc4", if_pc, 16'd4);

    reset_hold();
    clear_mem();
    mem[0] = 16'hD020;
    for (int i = 0; i < 8; i++)
      mem[32+i] = 16'hD021 + 16'(i);
    mem[40] = 16'hE000;
    release_rst();
    for (int i = 0; i < 9; i++) step();
    check("t6_ovf", ras_ovf, 1);
    check("t6_cnt8", 32'(dut.ras_count), 8);
    check("t6_unf0", ras_unf, 0);
    for (int i = 0; i < 20; i++) step();
    check("t6_ovf_sticky", ras_ovf, 1);
    rst_n = 1'b0;
    #1;
    check("t6_async_ovf", ras_ovf, 0);
    check("t6_async_valid", if_valid, 0);
    check("t6_async_addr", imem_addr, RST_PC);

    reset_hold();
    clear_mem();
    mem[0] = 16'hE000;
    release_rst();
    step(); check("t7_ret_pc", if_pc, 16'd0);
    check("t7_unf", ras_unf, 1);
    check("t7_addr", imem_addr, RST_PC);
    step(); check("t7_next_pc", if_pc, RST_PC);
    check("t7_cnt0", 32'(dut.ras_count), 0);

    step();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
